simeck_core_arbiter: RTL and testbench

- Shares one Simeck cipher datapath instance (32-bit block in, 16-bit key in, 32-bit block out) between two independent requesters.
- Accepts one request at a time via valid/ready and grants round-robin on contention.
- Drives the registered block and key into the core, waits a fixed core latency, then captures the core output and returns it to the owning requester via valid/ready.
- Sits between the system-side request sources and the cipher datapath.

---
 rtl/simeck_core_arbiter.sv | 106 ++++++++++
 tb/tb_simeck_core_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/simeck_core_arbiter.sv
// Two-requester front end for a shared Simeck datapath: round-robin grant,
// registered block/key into the core, fixed-latency capture, per-owner response.
module simeck_core_arbiter #(
   parameter int CORE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_data,
   input  logic [15:0] req0_key,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_data,
   input  logic [15:0] req1_key,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_data,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_data,
   output logic [31:0] core_inp,
   output logic [15:0] core_key,
   input  logic [31:0] core_out,
   output logic        busy,
   output logic [15:0] done_count
);

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] key;
   } req_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        owner;
   logic        last_grant;
   logic        grant;
   logic        accept;
   logic        take;
   logic [31:0] result;
   logic [15:0] done_cnt;
   req_t        req_sel;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant      = req1_valid & (~req0_valid | ~last_grant);
      req0_ready = ~rst & (state == IDLE) & req0_valid & ~grant;
      req1_ready = ~rst & (state == IDLE) & req1_valid & grant;
      accept     = req0_ready | req1_ready;
      req_sel    = grant ? {req1_data, req1_key} : {req0_data, req0_key};
      take       = (state == RESP) & (owner ? resp1_ready : resp0_ready);
      state_nxt  = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (cnt == 4'd1) state_nxt = RESP;
         RESP:    if (take) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= 4'd0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         core_inp   <= 32'd0;
         core_key   <= 16'd0;
         result     <= 32'd0;
         done_cnt   <= 16'd0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               core_inp <= req_sel.data;
               core_key <= req_sel.key;
               owner    <= grant;
               cnt      <= 4'(CORE_LAT);
            end
            RUN: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) result <= core_out;
            end
            RESP: if (take) begin
               last_grant <= owner;
               done_cnt   <= done_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign resp0_valid = (state == RESP) & ~owner;
   assign resp1_valid = (state == RESP) & owner;
   assign resp0_data  = result;
   assign resp1_data  = result;
   assign busy        = (state != IDLE);
   assign done_count  = done_cnt;

endmodule

// File: tb/tb_simeck_core_arbiter.sv
// Directed bench: three arbiters (CORE_LAT 1, 3, 5), each with an XOR core model.
module tb_simeck_core_arbiter;

   logic clk = 1'b0;
   logic clk_run = 1'b0;
   logic rst = 1'b0;

   logic        r0v[3], r0r[3], r1v[3], r1r[3];
   logic        s0v[3], s0r[3], s1v[3], s1r[3], bsy[3];
   logic [31:0] r0d[3], r1d[3], s0d[3], s1d[3], ci[3], co[3];
   logic [15:0] r0k[3], r1k[3], ck[3], dc[3];

   int n_chk = 0;
   int n_fail = 0;
   int cyc;

   always #5 clk = clk_run ? ~clk : clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int LAT = (k == 0) ? 1 : (k == 1) ? 3 : 5;
      simeck_core_arbiter #(.CORE_LAT(LAT)) u_dut (
         .clk(clk), .rst(rst),
         .req0_valid(r0v[k]), .req0_ready(r0r[k]), .req0_data(r0d[k]), .req0_key(r0k[k]),
         .req1_valid(r1v[k]), .req1_ready(r1r[k]), .req1_data(r1d[k]), .req1_key(r1k[k]),
         .resp0_valid(s0v[k]), .resp0_ready(s0r[k]), .resp0_data(s0d[k]),
         .resp1_valid(s1v[k]), .resp1_ready(s1r[k]), .resp1_data(s1d[k]),
         .core_inp(ci[k]), .core_key(ck[k]), .core_out(co[k]),
         .busy(bsy[k]), .done_count(dc[k])
      );
      assign co[k] = ci[k] ^ {ck[k], ck[k]};
   end

   // Returns the number of negedges after the accept edge until the owner's
   // resp_valid appears; 99 if it never does within the budget.
   task automatic wait_resp(input int k, input bit n, input bit drop, output int c);
      c = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (drop) begin r0v[k] = 1'b0; r1v[k] = 1'b0; end
         if ((n ? s1v[k] : s0v[k]) === 1'b1) return;
         c++;
      end
      c = 99;
   endtask

   task automatic test_reset();
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_chk++; if ({r0r[k], r1r[k], s0v[k], s1v[k], bsy[k]} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags[%0d]: got %b want 00000", k, {r0r[k], r1r[k], s0v[k], s1v[k], bsy[k]});
         end
         n_chk++; if (dc[k] !== 16'h0) begin
            n_fail++; $display("FAIL reset_done_count[%0d]: got %h want 0000", k, dc[k]);
         end
         n_chk++; if ({ci[k], ck[k], s0d[k]} !== 80'h0) begin
            n_fail++; $display("FAIL reset_core_regs[%0d]: got %h want 0", k, {ci[k], ck[k], s0d[k]});
         end
      end
      #3 clk_run = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      r0d[0] = 32'h00000005; r0k[0] = 16'hB5E5; s0r[0] = 1'b1; r0v[0] = 1'b1;
      #1;
      n_chk++; if ({r0r[0], r1r[0]} !== 2'b10) begin
         n_fail++; $display("FAIL single_ready: got %b want 10", {r0r[0], r1r[0]});
      end
      @(negedge clk); r0v[0] = 1'b0;
      n_chk++; if ({bsy[0], s0v[0], r0r[0], ci[0], ck[0]} !== {3'b100, 32'h00000005, 16'hB5E5}) begin
         n_fail++; $display("FAIL single_run: got %h want %h", {bsy[0], s0v[0], r0r[0], ci[0], ck[0]}, {3'b100, 32'h00000005, 16'hB5E5});
      end
      @(negedge clk);
      n_chk++; if ({s0v[0], s1v[0], s0d[0]} !== {2'b10, 32'hB5E5B5E0}) begin
         n_fail++; $display("FAIL single_resp: got %h want %h", {s0v[0], s1v[0], s0d[0]}, {2'b10, 32'hB5E5B5E0});
      end
      @(negedge clk);
      n_chk++; if ({s0v[0], bsy[0], dc[0]} !== {2'b00, 16'd1}) begin
         n_fail++; $display("FAIL single_done: got %h want %h", {s0v[0], bsy[0], dc[0]}, {2'b00, 16'd1});
      end
   endtask

   task automatic test_tie();
      r0d[1] = 32'h11111111; r0k[1] = 16'h0000; r1d[1] = 32'h22222222; r1k[1] = 16'hFFFF;
      s0r[1] = 1'b1; s1r[1] = 1'b1; r0v[1] = 1'b1; r1v[1] = 1'b1;
      #1;
      n_chk++; if ({r0r[1], r1r[1]} !== 2'b10) begin
         n_fail++; $display("FAIL tie_first_grant: got %b want 10", {r0r[1], r1r[1]});
      end
      wait_resp(1, 1'b0, 1'b0, cyc);
      n_chk++; if (cyc !== 3) begin
         n_fail++; $display("FAIL tie_lat0: got %0d want 3", cyc);
      end
      n_chk++; if ({s0d[1], s1v[1], r1r[1]} !== {32'h11111111, 2'b00}) begin
         n_fail++; $display("FAIL tie_resp0: got %h want %h", {s0d[1], s1v[1], r1r[1]}, {32'h11111111, 2'b00});
      end
      @(negedge clk);
      n_chk++; if ({r0r[1], r1r[1], dc[1]} !== {2'b01, 16'd1}) begin
         n_fail++; $display("FAIL tie_second_grant: got %h want %h", {r0r[1], r1r[1], dc[1]}, {2'b01, 16'd1});
      end
      wait_resp(1, 1'b1, 1'b0, cyc);
      n_chk++; if (cyc !== 3) begin
         n_fail++; $display("FAIL tie_lat1: got %0d want 3", cyc);
      end
      n_chk++; if ({s1d[1], s0v[1]} !== {32'hDDDDDDDD, 1'b0}) begin
         n_fail++; $display("FAIL tie_resp1: got %h want %h", {s1d[1], s0v[1]}, {32'hDDDDDDDD, 1'b0});
      end
      @(negedge clk);
      n_chk++; if ({r0r[1], r1r[1], dc[1]} !== {2'b10, 16'd2}) begin
         n_fail++; $display("FAIL tie_alternate: got %h want %h", {r0r[1], r1r[1], dc[1]}, {2'b10, 16'd2});
      end
      r0v[1] = 1'b0; r1v[1] = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      r1d[1] = 32'h12345678; r1k[1] = 16'h00FF; s1r[1] = 1'b0; r1v[1] = 1'b1;
      #1;
      n_chk++; if ({r0r[1], r1r[1]} !== 2'b01) begin
         n_fail++; $display("FAIL bp_grant: got %b want 01", {r0r[1], r1r[1]});
      end
      wait_resp(1, 1'b1, 1'b1, cyc);
      n_chk++; if (cyc !== 3) begin
         n_fail++; $display("FAIL bp_lat: got %0d want 3", cyc);
      end
      r0v[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_chk++; if ({s1v[1], s0v[1], r0r[1], bsy[1], s1d[1], dc[1]} !== {4'b1001, 32'h12CB5687, 16'd2}) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {s1v[1], s0v[1], r0r[1], bsy[1], s1d[1], dc[1]}, {4'b1001, 32'h12CB5687, 16'd2});
         end
      end
      s1r[1] = 1'b1;
      @(negedge clk);
      n_chk++; if ({s1v[1], r0r[1], dc[1]} !== {2'b01, 16'd3}) begin
         n_fail++; $display("FAIL bp_release: got %h want %h", {s1v[1], r0r[1], dc[1]}, {2'b01, 16'd3});
      end
      r0v[1] = 1'b0;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force g_dut[0].u_dut.done_cnt = 16'hFFFF;
      #1 release g_dut[0].u_dut.done_cnt;
      n_chk++; if (dc[0] !== 16'hFFFF) begin
         n_fail++; $display("FAIL wrap_preload: got %h want ffff", dc[0]);
      end
      r1d[0] = 32'hFFFFFFFF; r1k[0] = 16'h0001; s1r[0] = 1'b1; r1v[0] = 1'b1;
      #1;
      n_chk++; if ({r0r[0], r1r[0]} !== 2'b01) begin
         n_fail++; $display("FAIL wrap_grant: got %b want 01", {r0r[0], r1r[0]});
      end
      wait_resp(0, 1'b1, 1'b1, cyc);
      n_chk++; if ({cyc[7:0], s1d[0]} !== {8'd1, 32'hFFFEFFFE}) begin
         n_fail++; $display("FAIL wrap_resp: got %h want %h", {cyc[7:0], s1d[0]}, {8'd1, 32'hFFFEFFFE});
      end
      @(negedge clk);
      n_chk++; if (dc[0] !== 16'h0000) begin
         n_fail++; $display("FAIL wrap_count: got %h want 0000", dc[0]);
      end
   endtask

   task automatic test_reset_mid_run();
      r0d[2] = 32'hA5A5A5A5; r0k[2] = 16'h1234; s0r[2] = 1'b1; r0v[2] = 1'b1;
      #1;
      n_chk++; if (r0r[2] !== 1'b1) begin
         n_fail++; $display("FAIL mid_grant: got %b want 1", r0r[2]);
      end
      @(negedge clk); r0v[2] = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_chk++; if ({bsy[2], s0v[2], ci[2], ck[2]} !== 50'h0) begin
         n_fail++; $display("FAIL mid_reset_now: got %h want 0", {bsy[2], s0v[2], ci[2], ck[2]});
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_chk++; if ({s0v[2], dc[2]} !== 17'h0) begin
            n_fail++; $display("FAIL mid_no_resp[%0d]: got %h want 0", i, {s0v[2], dc[2]});
         end
      end
      r0d[2] = 32'h0F0F0F0F; r0k[2] = 16'hF0F0; r0v[2] = 1'b1;
      #1;
      n_chk++; if (r0r[2] !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_grant: got %b want 1", r0r[2]);
      end
      wait_resp(2, 1'b0, 1'b1, cyc);
      n_chk++; if ({cyc[7:0], s0d[2]} !== {8'd5, 32'hFFFFFFFF}) begin
         n_fail++; $display("FAIL post_reset_resp: got %h want %h", {cyc[7:0], s0d[2]}, {8'd5, 32'hFFFFFFFF});
      end
      @(negedge clk);
      n_chk++; if ({s0v[2], dc[2]} !== {1'b0, 16'd1}) begin
         n_fail++; $display("FAIL post_reset_done: got %h want %h", {s0v[2], dc[2]}, {1'b0, 16'd1});
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         r0v[k] = 1'b0; r1v[k] = 1'b0; s0r[k] = 1'b0; s1r[k] = 1'b0;
         r0d[k] = 32'h0; r1d[k] = 32'h0; r0k[k] = 16'h0; r1k[k] = 16'h0;
      end
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_wrap();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
